// File: rtl/axi_conf.sv
// axi_conf: shared AXI4 channel and request/response struct types used
// between the IO-PMP datapath and the master connector.
// Widths here must agree with the parameters of the connectors that use them.
package axi_conf;

    localparam int ID_W   = 8;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int STRB_W = DATA_W / 8;
    localparam int USER_W = 1;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic [5:0]        atop;
        logic [USER_W-1:0] user;
    } aw_chan_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [STRB_W-1:0] strb;
        logic              last;
        logic [USER_W-1:0] user;
    } w_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [1:0]        resp;
        logic [USER_W-1:0] user;
    } b_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
        logic [2:0]        size;
        logic [1:0]        burst;
        logic              lock;
        logic [3:0]        cache;
        logic [2:0]        prot;
        logic [3:0]        qos;
        logic [3:0]        region;
        logic [USER_W-1:0] user;
    } ar_chan_t;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
        logic [USER_W-1:0] user;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     ar_ready;
        logic     w_ready;
        logic     b_valid;
        b_chan_t  b;
        logic     r_valid;
        r_chan_t  r;
    } resp_t;

endpackage

// File: rtl/axi_master_connector_reg.sv
// axi_master_connector_reg
// Registered bridge from the PMP-side axi_conf request/response structs to a
// flat AXI4 master port. All five channels pass through an identical 2-entry
// skid buffer, so no combinational path crosses the block in either direction.
//
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   axi_req_i         AW/W/AR payload+valid, B/R ready from the PMP datapath
//   axi_resp_o        AW/W/AR ready, B/R payload+valid to the PMP datapath
//   m_axi_aw*/w*/ar*  request channels toward the fabric (outputs)
//   m_axi_b*/r*       response channels from the fabric (inputs)
module axi_master_connector_reg #(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int ID_WIDTH     = 8,
    parameter int AWUSER_WIDTH = 1,
    parameter int WUSER_WIDTH  = 1,
    parameter int BUSER_WIDTH  = 1,
    parameter int ARUSER_WIDTH = 1,
    parameter int RUSER_WIDTH  = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  axi_conf::req_t          axi_req_i,
    output axi_conf::resp_t         axi_resp_o,
    output logic [ID_WIDTH-1:0]     m_axi_awid,
    output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
    output logic [7:0]              m_axi_awlen,
    output logic [2:0]              m_axi_awsize,
    output logic [1:0]              m_axi_awburst,
    output logic                    m_axi_awlock,
    output logic [3:0]              m_axi_awcache,
    output logic [2:0]              m_axi_awprot,
    output logic [3:0]              m_axi_awqos,
    output logic [3:0]              m_axi_awregion,
    output logic [AWUSER_WIDTH-1:0] m_axi_awuser,
    output logic                    m_axi_awvalid,
    input  logic                    m_axi_awready,
    output logic [DATA_WIDTH-1:0]   m_axi_wdata,
    output logic [STRB_WIDTH-1:0]   m_axi_wstrb,
    output logic                    m_axi_wlast,
    output logic [WUSER_WIDTH-1:0]  m_axi_wuser,
    output logic                    m_axi_wvalid,
    input  logic                    m_axi_wready,
    input  logic [ID_WIDTH-1:0]     m_axi_bid,
    input  logic [1:0]              m_axi_bresp,
    input  logic [BUSER_WIDTH-1:0]  m_axi_buser,
    input  logic                    m_axi_bvalid,
    output logic                    m_axi_bready,
    output logic [ID_WIDTH-1:0]     m_axi_arid,
    output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
    output logic [7:0]              m_axi_arlen,
    output logic [2:0]              m_axi_arsize,
    output logic [1:0]              m_axi_arburst,
    output logic                    m_axi_arlock,
    output logic [3:0]              m_axi_arcache,
    output logic [2:0]              m_axi_arprot,
    output logic [3:0]              m_axi_arqos,
    output logic [3:0]              m_axi_arregion,
    output logic [ARUSER_WIDTH-1:0] m_axi_aruser,
    output logic                    m_axi_arvalid,
    input  logic                    m_axi_arready,
    input  logic [ID_WIDTH-1:0]     m_axi_rid,
    input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
    input  logic [1:0]              m_axi_rresp,
    input  logic                    m_axi_rlast,
    input  logic [RUSER_WIDTH-1:0]  m_axi_ruser,
    input  logic                    m_axi_rvalid,
    output logic                    m_axi_rready
);

    // Payload widths per channel; all five payloads share one flat vector,
    // AW in the low bits, then W, B, AR, R.
    localparam int W_AW = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4 + AWUSER_WIDTH;
    localparam int W_W  = DATA_WIDTH + STRB_WIDTH + 1 + WUSER_WIDTH;
    localparam int W_B  = ID_WIDTH + 2 + BUSER_WIDTH;
    localparam int W_AR = ID_WIDTH + ADDR_WIDTH + 8 + 3 + 2 + 1 + 4 + 3 + 4 + 4 + ARUSER_WIDTH;
    localparam int W_R  = ID_WIDTH + DATA_WIDTH + 2 + 1 + RUSER_WIDTH;

    localparam int LO_AW = 0;
    localparam int LO_W  = LO_AW + W_AW;
    localparam int LO_B  = LO_W + W_W;
    localparam int LO_AR = LO_B + W_B;
    localparam int LO_R  = LO_AR + W_AR;
    localparam int TOT   = LO_R + W_R;

    localparam int CH_W  [5] = '{W_AW, W_W, W_B, W_AR, W_R};
    localparam int CH_LO [5] = '{LO_AW, LO_W, LO_B, LO_AR, LO_R};

    logic [TOT-1:0] in_all;
    logic [TOT-1:0] out_all;
    logic [4:0]     in_valid;
    logic [4:0]     in_ready;
    logic [4:0]     out_valid;
    logic [4:0]     out_ready;

    // atop is deliberately not forwarded to the fabric.
    logic unused_atop;
    assign unused_atop = ^axi_req_i.aw.atop;

    assign in_all = {
        m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_ruser,
        axi_req_i.ar,
        m_axi_bid, m_axi_bresp, m_axi_buser,
        axi_req_i.w,
        axi_req_i.aw.id, axi_req_i.aw.addr, axi_req_i.aw.len, axi_req_i.aw.size,
        axi_req_i.aw.burst, axi_req_i.aw.lock, axi_req_i.aw.cache, axi_req_i.aw.prot,
        axi_req_i.aw.qos, axi_req_i.aw.region, axi_req_i.aw.user
    };

    assign in_valid  = {m_axi_rvalid, axi_req_i.ar_valid, m_axi_bvalid,
                        axi_req_i.w_valid, axi_req_i.aw_valid};
    assign out_ready = {axi_req_i.r_ready, m_axi_arready, axi_req_i.b_ready,
                        m_axi_wready, m_axi_awready};

    for (genvar c = 0; c < 5; c++) begin : g_ch
        localparam int CW = CH_W[c];
        localparam int LO = CH_LO[c];

        logic          valid_q;
        logic          skid_valid_q;
        logic [CW-1:0] data_q;
        logic [CW-1:0] skid_q;
        logic          in_fire;
        logic          out_fire;

        assign in_ready[c]         = !skid_valid_q;
        assign out_valid[c]        = valid_q;
        assign out_all[LO +: CW]   = data_q;
        assign in_fire             = in_valid[c] && !skid_valid_q;
        assign out_fire            = valid_q && out_ready[c];

        // EMPTY -> FULL1 on input; FULL1 -> EMPTY on output only, -> FULL2 on
        // input only; FULL2 -> FULL1 on output. Both firing in FULL1 stays put.
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                valid_q      <= 1'b0;
                skid_valid_q <= 1'b0;
            end else if (!valid_q) begin
                valid_q <= in_fire;
            end else if (!skid_valid_q) begin
                if (out_fire && !in_fire) begin
                    valid_q <= 1'b0;
                end else if (in_fire && !out_fire) begin
                    skid_valid_q <= 1'b1;
                end
            end else if (out_fire) begin
                skid_valid_q <= 1'b0;
            end
        end

        // Payload registers carry no reset; they are only observed with valid.
        always_ff @(posedge clk_i) begin
            if (in_fire && (!valid_q || out_fire)) begin
                data_q <= in_all[LO +: CW];
            end else if (skid_valid_q && out_fire) begin
                data_q <= skid_q;
            end
            if (in_fire && valid_q && !out_fire) begin
                skid_q <= in_all[LO +: CW];
            end
        end
    end

    assign {m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
            m_axi_awlock, m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awregion,
            m_axi_awuser} = out_all[LO_AW +: W_AW];
    assign {m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wuser} = out_all[LO_W +: W_W];
    assign {m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst,
            m_axi_arlock, m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arregion,
            m_axi_aruser} = out_all[LO_AR +: W_AR];

    assign m_axi_awvalid = out_valid[0];
    assign m_axi_wvalid  = out_valid[1];
    assign m_axi_arvalid = out_valid[3];
    assign m_axi_bready  = in_ready[2];
    assign m_axi_rready  = in_ready[4];

    always_comb begin
        axi_resp_o          = '0;
        axi_resp_o.aw_ready = in_ready[0];
        axi_resp_o.w_ready  = in_ready[1];
        axi_resp_o.ar_ready = in_ready[3];
        axi_resp_o.b_valid  = out_valid[2];
        axi_resp_o.b        = out_all[LO_B +: W_B];
        axi_resp_o.r_valid  = out_valid[4];
        axi_resp_o.r        = out_all[LO_R +: W_R];
    end

endmodule

// File: tb/tb_axi_master_connector_reg.sv
module tb_axi_master_connector_reg;

    logic clk = 1'b0;
    logic rst = 1'b1;

    axi_conf::req_t  req;
    axi_conf::resp_t resp;

    logic [7:0]  m_axi_awid;   logic [31:0] m_axi_awaddr; logic [7:0] m_axi_awlen;
    logic [2:0]  m_axi_awsize; logic [1:0]  m_axi_awburst; logic m_axi_awlock;
    logic [3:0]  m_axi_awcache; logic [2:0] m_axi_awprot; logic [3:0] m_axi_awqos;
    logic [3:0]  m_axi_awregion; logic [0:0] m_axi_awuser;
    logic        m_axi_awvalid, m_axi_awready;
    logic [31:0] m_axi_wdata; logic [3:0] m_axi_wstrb; logic m_axi_wlast; logic [0:0] m_axi_wuser;
    logic        m_axi_wvalid, m_axi_wready;
    logic [7:0]  m_axi_bid; logic [1:0] m_axi_bresp; logic [0:0] m_axi_buser;
    logic        m_axi_bvalid, m_axi_bready;
    logic [7:0]  m_axi_arid;   logic [31:0] m_axi_araddr; logic [7:0] m_axi_arlen;
    logic [2:0]  m_axi_arsize; logic [1:0]  m_axi_arburst; logic m_axi_arlock;
    logic [3:0]  m_axi_arcache; logic [2:0] m_axi_arprot; logic [3:0] m_axi_arqos;
    logic [3:0]  m_axi_arregion; logic [0:0] m_axi_aruser;
    logic        m_axi_arvalid, m_axi_arready;
    logic [7:0]  m_axi_rid; logic [31:0] m_axi_rdata; logic [1:0] m_axi_rresp;
    logic        m_axi_rlast; logic [0:0] m_axi_ruser;
    logic        m_axi_rvalid, m_axi_rready;

    axi_master_connector_reg dut (
        .clk_i(clk), .rst_i(rst), .axi_req_i(req), .axi_resp_o(resp),
        .m_axi_awid(m_axi_awid), .m_axi_awaddr(m_axi_awaddr), .m_axi_awlen(m_axi_awlen),
        .m_axi_awsize(m_axi_awsize), .m_axi_awburst(m_axi_awburst), .m_axi_awlock(m_axi_awlock),
        .m_axi_awcache(m_axi_awcache), .m_axi_awprot(m_axi_awprot), .m_axi_awqos(m_axi_awqos),
        .m_axi_awregion(m_axi_awregion), .m_axi_awuser(m_axi_awuser),
        .m_axi_awvalid(m_axi_awvalid), .m_axi_awready(m_axi_awready),
        .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb), .m_axi_wlast(m_axi_wlast),
        .m_axi_wuser(m_axi_wuser), .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready),
        .m_axi_bid(m_axi_bid), .m_axi_bresp(m_axi_bresp), .m_axi_buser(m_axi_buser),
        .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready),
        .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
        .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst), .m_axi_arlock(m_axi_arlock),
        .m_axi_arcache(m_axi_arcache), .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
        .m_axi_arregion(m_axi_arregion), .m_axi_aruser(m_axi_aruser),
        .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
        .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
        .m_axi_rlast(m_axi_rlast), .m_axi_ruser(m_axi_ruser),
        .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference: each channel is an in-order FIFO holding at most two beats.
    // Upstream ready means "fewer than two held", downstream valid means
    // "at least one held", downstream payload is the oldest held beat.
    logic [69:0] mq [5][2];
    int          occ [5];
    bit          fin [5];
    bit          fout [5];
    logic [69:0] last_out [5];
    string       nm [5] = '{"aw", "w", "b", "ar", "r"};

    task automatic model_reset();
        for (int i = 0; i < 5; i++) begin
            occ[i] = 0; fin[i] = 0; fout[i] = 0;
        end
    endtask

    task automatic expect_eq(input string tag, input logic [69:0] got, input logic [69:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic chk(input int ch, input logic iv, input logic ir, input logic [69:0] id,
                       input logic ov, input logic orr, input logic [69:0] od);
        bit m_in;
        bit m_out;
        vectors++;
        assert (ov === (occ[ch] > 0)) else begin
            miscompares++;
            $error("FAIL %s_valid observed=%b expected=%b", nm[ch], ov, occ[ch] > 0);
        end
        vectors++;
        assert (ir === (occ[ch] < 2)) else begin
            miscompares++;
            $error("FAIL %s_ready observed=%b expected=%b", nm[ch], ir, occ[ch] < 2);
        end
        m_out = (occ[ch] > 0) && (orr === 1'b1);
        m_in  = (iv === 1'b1) && (occ[ch] < 2);
        if (m_out) begin
            vectors++;
            assert (od === mq[ch][0]) else begin
                miscompares++;
                $error("FAIL %s_payload observed=%h expected=%h", nm[ch], od, mq[ch][0]);
            end
            last_out[ch] = od;
            mq[ch][0] = mq[ch][1];
            occ[ch]--;
        end
        if (m_in) begin
            mq[ch][occ[ch]] = id;
            occ[ch]++;
        end
        fin[ch]  = m_in;
        fout[ch] = m_out;
    endtask

    task automatic check_all();
        chk(0, req.aw_valid, resp.aw_ready,
            70'({req.aw.id, req.aw.addr, req.aw.len, req.aw.size, req.aw.burst, req.aw.lock,
                 req.aw.cache, req.aw.prot, req.aw.qos, req.aw.region, req.aw.user}),
            m_axi_awvalid, m_axi_awready,
            70'({m_axi_awid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst, m_axi_awlock,
                 m_axi_awcache, m_axi_awprot, m_axi_awqos, m_axi_awregion, m_axi_awuser}));
        chk(1, req.w_valid, resp.w_ready,
            70'({req.w.data, req.w.strb, req.w.last, req.w.user}),
            m_axi_wvalid, m_axi_wready,
            70'({m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_wuser}));
        chk(2, m_axi_bvalid, m_axi_bready,
            70'({m_axi_bid, m_axi_bresp, m_axi_buser}),
            resp.b_valid, req.b_ready,
            70'({resp.b.id, resp.b.resp, resp.b.user}));
        chk(3, req.ar_valid, resp.ar_ready,
            70'({req.ar.id, req.ar.addr, req.ar.len, req.ar.size, req.ar.burst, req.ar.lock,
                 req.ar.cache, req.ar.prot, req.ar.qos, req.ar.region, req.ar.user}),
            m_axi_arvalid, m_axi_arready,
            70'({m_axi_arid, m_axi_araddr, m_axi_arlen, m_axi_arsize, m_axi_arburst, m_axi_arlock,
                 m_axi_arcache, m_axi_arprot, m_axi_arqos, m_axi_arregion, m_axi_aruser}));
        chk(4, m_axi_rvalid, m_axi_rready,
            70'({m_axi_rid, m_axi_rdata, m_axi_rresp, m_axi_rlast, m_axi_ruser}),
            resp.r_valid, req.r_ready,
            70'({resp.r.id, resp.r.data, resp.r.resp, resp.r.last, resp.r.user}));
    endtask

    // Called at a negedge with inputs already driven: check the state the next
    // rising edge will see, then advance to the following negedge.
    task automatic tick();
        #1;
        if (!rst) check_all();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        req = '0;
        m_axi_awready = 1'b0; m_axi_wready = 1'b0; m_axi_arready = 1'b0;
        m_axi_bvalid = 1'b0; m_axi_bid = '0; m_axi_bresp = '0; m_axi_buser = '0;
        m_axi_rvalid = 1'b0; m_axi_rid = '0; m_axi_rdata = '0; m_axi_rresp = '0;
        m_axi_rlast = 1'b0; m_axi_ruser = '0;
    endtask

    task automatic rand_inputs();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        req.aw = r[$bits(axi_conf::aw_chan_t)-1:0];
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        req.ar = r[$bits(axi_conf::ar_chan_t)-1:0];
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        req.w  = r[$bits(axi_conf::w_chan_t)-1:0];
        req.aw_valid = 1'($urandom_range(0, 1));
        req.w_valid  = 1'($urandom_range(0, 1));
        req.ar_valid = 1'($urandom_range(0, 1));
        req.b_ready  = 1'($urandom_range(0, 1));
        req.r_ready  = 1'($urandom_range(0, 1));
        m_axi_awready = 1'($urandom_range(0, 1));
        m_axi_wready  = 1'($urandom_range(0, 1));
        m_axi_arready = 1'($urandom_range(0, 1));
        m_axi_bvalid = 1'($urandom_range(0, 1));
        m_axi_bid = 8'($urandom()); m_axi_bresp = 2'($urandom()); m_axi_buser = 1'($urandom());
        m_axi_rvalid = 1'($urandom_range(0, 1));
        m_axi_rid = 8'($urandom()); m_axi_rdata = $urandom(); m_axi_rresp = 2'($urandom());
        m_axi_rlast = 1'($urandom()); m_axi_ruser = 1'($urandom());
    endtask

    task automatic check_reset_state(input string tag);
        expect_eq({tag, "_awvalid"}, 70'(m_axi_awvalid), 70'(0));
        expect_eq({tag, "_wvalid"},  70'(m_axi_wvalid),  70'(0));
        expect_eq({tag, "_arvalid"}, 70'(m_axi_arvalid), 70'(0));
        expect_eq({tag, "_bvalid"},  70'(resp.b_valid),  70'(0));
        expect_eq({tag, "_rvalid"},  70'(resp.r_valid),  70'(0));
        expect_eq({tag, "_awready"}, 70'(resp.aw_ready), 70'(1));
        expect_eq({tag, "_wready"},  70'(resp.w_ready),  70'(1));
        expect_eq({tag, "_arready"}, 70'(resp.ar_ready), 70'(1));
        expect_eq({tag, "_bready"},  70'(m_axi_bready),  70'(1));
        expect_eq({tag, "_rready"},  70'(m_axi_rready),  70'(1));
    endtask

    logic [31:0] got_d [8];
    logic        got_l [8];

    initial begin
        clear_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check_reset_state("rst");
        rst = 1'b0;

        // Single write with response.
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; req.b_ready = 1'b1;
        req.aw = '0; req.aw.addr = 32'h1000; req.aw.id = 8'd3; req.aw.size = 3'd2;
        req.aw.burst = 2'd1; req.aw_valid = 1'b1;
        req.w.data = 32'hDEADBEEF; req.w.strb = 4'hF; req.w.last = 1'b1; req.w_valid = 1'b1;
        tick();
        req.aw_valid = 1'b0; req.w_valid = 1'b0;
        expect_eq("wr_awvalid", 70'(m_axi_awvalid), 70'(1));
        expect_eq("wr_awaddr",  70'(m_axi_awaddr),  70'(32'h1000));
        expect_eq("wr_awid",    70'(m_axi_awid),    70'(3));
        expect_eq("wr_wvalid",  70'(m_axi_wvalid),  70'(1));
        expect_eq("wr_wdata",   70'(m_axi_wdata),   70'(32'hDEADBEEF));
        expect_eq("wr_wlast",   70'(m_axi_wlast),   70'(1));
        tick();
        m_axi_bvalid = 1'b1; m_axi_bid = 8'd3; m_axi_bresp = 2'd0;
        tick();
        m_axi_bvalid = 1'b0;
        expect_eq("wr_bvalid", 70'(resp.b_valid), 70'(1));
        expect_eq("wr_bid",    70'(resp.b.id),    70'(3));
        expect_eq("wr_bresp",  70'(resp.b.resp),  70'(0));
        tick();

        // 16-beat W burst at full rate.
        for (int i = 0; i < 16; i++) begin
            req.w_valid = 1'b1; req.w.data = 32'(i); req.w.strb = 4'hF; req.w.last = (i == 15);
            tick();
            expect_eq("burst_wvalid", 70'(m_axi_wvalid), 70'(1));
            expect_eq("burst_wdata",  70'(m_axi_wdata),  70'(i));
            expect_eq("burst_wlast",  70'(m_axi_wlast),  70'(i == 15));
        end
        req.w_valid = 1'b0;
        tick();
        expect_eq("burst_drained", 70'(m_axi_wvalid), 70'(0));

        // AR backpressure: second request lands in the skid slot.
        m_axi_arready = 1'b0;
        req.ar = '0; req.ar_valid = 1'b1; req.ar.addr = 32'hA000_0000;
        tick();
        req.ar.addr = 32'hA000_0040;
        tick();
        req.ar_valid = 1'b0;
        expect_eq("bp_arready_low", 70'(resp.ar_ready), 70'(0));
        expect_eq("bp_araddr0",     70'(m_axi_araddr),  70'(32'hA000_0000));
        tick();
        m_axi_arready = 1'b1;
        tick();
        expect_eq("bp_araddr1",      70'(m_axi_araddr),  70'(32'hA000_0040));
        expect_eq("bp_arvalid1",     70'(m_axi_arvalid), 70'(1));
        expect_eq("bp_arready_back", 70'(resp.ar_ready), 70'(1));
        tick();
        expect_eq("bp_arvalid_done", 70'(m_axi_arvalid), 70'(0));

        // R burst of 8 beats with the PMP side toggling r_ready.
        begin
            int k = 0;
            int n = 0;
            int c = 0;
            while (n < 8 && c < 64) begin
                req.r_ready = (c % 2 == 0);
                m_axi_rvalid = (k < 8); m_axi_rid = 8'd5; m_axi_rdata = 32'h100 + 32'(k);
                m_axi_rlast = (k == 7); m_axi_rresp = 2'd0; m_axi_ruser = 1'b0;
                tick();
                if (fin[4]) k++;
                if (fout[4]) begin
                    got_d[n] = last_out[4][35:4];
                    got_l[n] = last_out[4][1];
                    n++;
                end
                c++;
            end
            m_axi_rvalid = 1'b0;
            expect_eq("r_beats", 70'(n), 70'(8));
            for (int j = 0; j < n; j++) begin
                expect_eq("r_data", 70'(got_d[j]), 70'(32'h100 + 32'(j)));
                expect_eq("r_last", 70'(got_l[j]), 70'(j == 7));
            end
            req.r_ready = 1'b1;
            repeat (3) tick();
        end

        // Concurrent random traffic on all five channels.
        for (int i = 0; i < 10000; i++) begin
            rand_inputs();
            tick();
        end
        clear_inputs();
        m_axi_awready = 1'b1; m_axi_wready = 1'b1; m_axi_arready = 1'b1;
        req.b_ready = 1'b1; req.r_ready = 1'b1;
        repeat (4) tick();

        // Reset while the W skid buffer is full and a third beat is offered.
        m_axi_wready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req.w_valid = 1'b1; req.w.data = 32'hB000 + 32'(i); req.w.strb = 4'hF; req.w.last = 1'b0;
            tick();
        end
        expect_eq("mid_wready_full", 70'(resp.w_ready), 70'(0));
        req.w.data = 32'hB002;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_reset_state("mid_rst_async");
        clear_inputs();
        @(negedge clk);
        @(negedge clk);
        check_reset_state("mid_rst_hold");
        rst = 1'b0;
        m_axi_wready = 1'b1; m_axi_awready = 1'b1; m_axi_arready = 1'b1;
        req.b_ready = 1'b1; req.r_ready = 1'b1;
        repeat (4) tick();
        expect_eq("post_rst_wvalid", 70'(m_axi_wvalid), 70'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_master_connector_reg.md
Name: axi_master_connector_reg

Overview:
- Master-side counterpart of the slave connector: takes an axi_conf::req_t / axi_conf::resp_t pair from the IO-PMP datapath and drives a flat m_axi_* AXI4 master port toward downstream fabric/memory.
- Every one of the five channels passes through a 2-entry skid buffer (main + skid register). No combinational valid→ready or ready→valid path crosses the block, so it also acts as a timing cut between PMP logic and the fabric.

Parameters:
- DATA_WIDTH, 32, data bus width in bits
- ADDR_WIDTH, 32, address width in bits
- STRB_WIDTH, DATA_WIDTH/8, strobe width
- ID_WIDTH, 8, AXI ID width
- AWUSER_WIDTH / WUSER_WIDTH / BUSER_WIDTH / ARUSER_WIDTH / RUSER_WIDTH, 1, user widths per channel

Ports:
- clk_i  input  1  single clock, all logic rising-edge
- rst_i  input  1  asynchronous, active-high reset
- axi_req_i  input  axi_conf::req_t  request struct from the PMP datapath
- axi_resp_o  output  axi_conf::resp_t  response struct to the PMP datapath
- m_axi_aw{id,addr,len,size,burst,lock,cache,prot,qos,region,user}  output  ID_WIDTH/ADDR_WIDTH/8/3/2/1/4/3/4/4/AWUSER_WIDTH  AW payload
- m_axi_awvalid  output  1 / m_axi_awready  input  1  AW handshake
- m_axi_w{data,strb,last,user}  output  DATA_WIDTH/STRB_WIDTH/1/WUSER_WIDTH  W payload
- m_axi_wvalid  output  1 / m_axi_wready  input  1  W handshake
- m_axi_b{id,resp,user}  input  ID_WIDTH/2/BUSER_WIDTH  B payload
- m_axi_bvalid  input  1 / m_axi_bready  output  1  B handshake
- m_axi_ar{id,addr,len,size,burst,lock,cache,prot,qos,region,user}  output  same widths as AW  AR payload
- m_axi_arvalid  output  1 / m_axi_arready  input  1  AR handshake
- m_axi_r{id,data,resp,last,user}  input  ID_WIDTH/DATA_WIDTH/2/1/RUSER_WIDTH  R payload
- m_axi_rvalid  input  1 / m_axi_rready  output  1  R handshake

Behaviour:
- Per-channel skid buffer, identical instance ×5 (AW, W, AR: req→m_axi; B, R: m_axi→resp). Each instance has two regs: main (valid_q, data_q) and skid (skid_valid_q, skid_q).
- Upstream ready = !skid_valid_q. This is a pure register output.
- Downstream valid = valid_q. Downstream payload = data_q.
- States per channel:
  - EMPTY (!valid_q): an input handshake loads main. Next state is FULL1.
  - FULL1 (valid_q, !skid): input and output fire together, main reloads, stay FULL1. Only output fires: go to EMPTY. Only input fires (output stalled): load skid, go to FULL2.
  - FULL2 (valid_q, skid): upstream ready=0. An output handshake moves skid into main and goes to FULL1.
- Latency 1 cycle input→output. Sustained throughput 1 beat/cycle with downstream ready held high.
- Payload and valid remain stable while valid && !ready, per AXI. Beat order is strictly preserved. No reordering between channels; AW/W/B/AR/R are fully independent.
- Payload width is the full struct field width, copied bit-exactly. No width conversion. atop is not carried.
- Reset (rst_i=1, async):
  - All valid_q and skid_valid_q clear immediately, so m_axi_awvalid, m_axi_wvalid, m_axi_arvalid and axi_resp_o.b_valid/r_valid are 0.
  - Readies (axi_resp_o.aw_ready/w_ready/ar_ready, m_axi_bready, m_axi_rready) are 1 during and after reset because skid is empty. Upstream must not assert valid during reset.
  - Payload registers are not reset; their value is don't-care while valid=0.
- Reset mid-burst drops all buffered beats on every channel. No recovery of partial bursts.
- Simultaneous input and output handshake in FULL1 is neither loss nor duplication. Input and output handshake in FULL2 cannot occur (upstream ready=0).

Test Plan:
- Single write: AW addr=0x1000 len=0 id=3 plus W data=0xDEADBEEF strb=0xF last=1, downstream ready=1 → m_axi_awvalid and m_axi_wvalid high 1 cycle after the input handshake with identical payload. B id=3 resp=OKAY → axi_resp_o.b valid 1 cycle later.
- Back-to-back throughput: 16-beat W burst (data=0..15), m_axi_wready=1 → 16 consecutive output beats, no bubbles, wlast only on beat 15.
- Backpressure: m_axi_arready=0 with two AR requests → second is captured in skid, then axi_resp_o.ar_ready=0. Releasing ready → both issue in order on consecutive cycles, ar_ready returns to 1 after skid drains.
- R burst len=7 with axi_req_i.r_ready toggling 1/0 each cycle → all 8 beats delivered in order, rlast on beat 7 only, no beat duplicated.
- Concurrent read and write traffic with random ready/valid on all five channels for 10k cycles → scoreboard matches per channel in order.
- Reset mid-burst: assert rst_i during beat 3 of an 8-beat write with skid full → all valids 0 in the same cycle (async), readies 1 after release, and no stale beat appears afterwards.
